// File: rtl/conv_pkg.sv
// Shared defaults and helpers for the conv_12x12 -> relu_maxpool_2x2 pipeline.
package conv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMG_W  = 10;
  localparam int unsigned IMG_H  = 10;

  typedef enum logic {
    S_EVEN,
    S_ODD
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Holds the even-row horizontal pair maxima until the odd row below completes each window.
module pool_line_buf #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 5,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  // Not reset: every entry is rewritten on an even row before the odd row reads it.
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a row-major conv result stream.
module relu_maxpool_2x2
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W  = conv_pkg::DATA_W,
  parameter int unsigned IMG_W   = conv_pkg::IMG_W,
  parameter int unsigned IMG_H   = conv_pkg::IMG_H,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_port,
  input  logic              in_invalid,
  output logic [DATA_W-1:0] output_port,
  output logic              invalid,
  output logic              finish
);

  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned Half  = IMG_W / 2;
  localparam int unsigned AddrW = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  pool_state_t     state_q, state_d;

  logic signed [DATA_W-1:0] x, pair_q, pair_d, lbuf_rdata, lbuf_wdata, result, out_q;
  logic [AddrW-1:0] lbuf_addr;
  logic beat, col_last, row_last, lbuf_we, res_valid, res_last, invalid_q, finish_q;

  assign beat      = ~in_invalid;
  assign col_last  = (col_q == ColLast);
  assign row_last  = (row_q == RowLast);
  assign x         = (RELU_EN && input_port[DATA_W-1]) ? '0 : input_port;
  assign lbuf_addr = AddrW'(col_q >> 1);

  pool_line_buf #(
    .DataW (DATA_W),
    .Depth (Half),
    .AddrW (AddrW)
  ) u_line_buf (
    .clk_i   (clk),
    .we_i    (lbuf_we),
    .addr_i  (lbuf_addr),
    .wdata_i (lbuf_wdata),
    .rdata_o (lbuf_rdata)
  );

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    state_d    = state_q;
    pair_d     = pair_q;
    lbuf_we    = 1'b0;
    lbuf_wdata = smax(pair_q, x);
    result     = smax(smax(pair_q, x), lbuf_rdata);
    res_valid  = 1'b0;
    res_last   = 1'b0;
    if (beat) begin
      col_d = col_last ? '0 : col_q + ColW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RowW'(1);
      unique case (state_q)
        S_EVEN: begin
          if (!col_q[0]) pair_d = x;
          else           lbuf_we = 1'b1;
          if (col_last) state_d = S_ODD;
        end
        S_ODD: begin
          if (!col_q[0]) begin
            pair_d = x;
          end else begin
            res_valid = 1'b1;
            res_last  = row_last && col_last;
          end
          if (col_last) state_d = S_EVEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q     <= '0;
      row_q     <= '0;
      state_q   <= S_EVEN;
      pair_q    <= '0;
      out_q     <= '0;
      invalid_q <= 1'b1;
      finish_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      state_q   <= state_d;
      pair_q    <= pair_d;
      if (res_valid) out_q <= result;
      invalid_q <= ~res_valid;
      finish_q  <= res_last;
    end
  end

  assign output_port = out_q;
  assign invalid     = invalid_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench: ReLU and plain-max instances driven in parallel from one stimulus stream.
module tb_relu_maxpool_2x2;

  localparam int W = 10;
  localparam int H = 10;

  typedef struct {
    logic [31:0] val;
    logic        fin;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input_port;
  logic        in_invalid;
  logic [31:0] out_r, out_n;
  logic        inv_r, inv_n, fin_r, fin_n;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q_r[$];
  exp_t q_n[$];
  int   img[W*H];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool_2x2 #(.DATA_W(32), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b1)) dut_r (
    .clk         (clk),
    .reset       (reset),
    .input_port  (input_port),
    .in_invalid  (in_invalid),
    .output_port (out_r),
    .invalid     (inv_r),
    .finish      (fin_r)
  );

  relu_maxpool_2x2 #(.DATA_W(32), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b0)) dut_n (
    .clk         (clk),
    .reset       (reset),
    .input_port  (input_port),
    .in_invalid  (in_invalid),
    .output_port (out_n),
    .invalid     (inv_n),
    .finish      (fin_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int win_max(input int wr, input int wc, input bit relu);
    int m;
    int v;
    m = 32'sh8000_0000;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        v = img[(2*wr+dr)*W + 2*wc+dc];
        if (relu && v < 0) v = 0;
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

  // mode 0 ramp, 1 all -5, 2 mixed first window, 3 all-negative first window
  task automatic load_img(input int mode);
    for (int p = 0; p < W*H; p++) begin
      unique case (mode)
        0:       img[p] = p;
        1:       img[p] = -5;
        default: img[p] = 0;
      endcase
    end
    if (mode == 2) begin img[0] = -7; img[1] = 3;  img[W] = 9;  img[W+1] = -2; end
    if (mode == 3) begin img[0] = -7; img[1] = -3; img[W] = -9; img[W+1] = -2; end
  endtask

  task automatic run_frame(input int mode, input bit gap, input int nbeats);
    exp_t e;
    int r;
    int c;
    load_img(mode);
    for (int p = 0; p < nbeats; p++) begin
      r = p / W;
      c = p % W;
      in_invalid = 1'b0;
      input_port = img[p];
      if (r[0] && c[0]) begin
        e.fin = (p == W*H-1);
        e.cyc = cyc + 1;
        e.val = win_max(r/2, c/2, 1'b1);
        q_r.push_back(e);
        e.val = win_max(r/2, c/2, 1'b0);
        q_n.push_back(e);
      end
      @(negedge clk);
      if (gap) begin
        in_invalid = 1'b1;
        @(negedge clk);
      end
    end
    in_invalid = 1'b1;
  endtask

  task automatic idle(input int n);
    in_invalid = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_out_r", out_r, 32'd0);
    check_eq("rst_inv_r", {31'd0, inv_r}, 32'd1);
    check_eq("rst_fin_r", {31'd0, fin_r}, 32'd0);
    check_eq("rst_out_n", out_n, 32'd0);
    check_eq("rst_inv_n", {31'd0, inv_n}, 32'd1);
    check_eq("rst_fin_n", {31'd0, fin_n}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!inv_r) begin
      check_eq("r_pending", {31'd0, q_r.size() != 0}, 32'd1);
      if (q_r.size() != 0) begin
        e = q_r.pop_front();
        check_eq("r_val", out_r, e.val);
        check_eq("r_fin", {31'd0, fin_r}, {31'd0, e.fin});
        check_eq("r_lat", cyc, e.cyc);
      end
    end else if (fin_r) begin
      check_eq("r_fin_idle", {31'd0, fin_r}, 32'd0);
    end
    if (!inv_n) begin
      check_eq("n_pending", {31'd0, q_n.size() != 0}, 32'd1);
      if (q_n.size() != 0) begin
        e = q_n.pop_front();
        check_eq("n_val", out_n, e.val);
        check_eq("n_fin", {31'd0, fin_n}, {31'd0, e.fin});
        check_eq("n_lat", cyc, e.cyc);
      end
    end else if (fin_n) begin
      check_eq("n_fin_idle", {31'd0, fin_n}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    in_invalid = 1'b1;
    input_port = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    idle(2);

    run_frame(0, 1'b0, W*H);  // ramp
    idle(3);
    check_eq("hold_r", out_r, 32'd99);
    check_eq("hold_n", out_n, 32'd99);

    run_frame(1, 1'b0, W*H);  // negatives
    idle(2);
    run_frame(2, 1'b0, W*H);  // mixed window
    idle(2);
    run_frame(3, 1'b0, W*H);  // all-negative window
    idle(2);
    run_frame(0, 1'b1, W*H);  // ramp with gaps
    idle(2);

    run_frame(0, 1'b0, 37);   // partial frame, then reset
    idle(2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    run_frame(0, 1'b0, W*H);
    idle(2);

    run_frame(0, 1'b0, W*H);  // back-to-back frames
    run_frame(0, 1'b0, W*H);
    idle(4);

    check_eq("sb_empty_r", q_r.size(), 32'd0);
    check_eq("sb_empty_n", q_n.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
